fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Fetch stage that drives the processor front end. Owns the fetch PC and issues
//  word requests to a variable-latency instruction memory over a req/ack handshake.
//  Queues {pc, instruction} pairs in a small FIFO for the decode/parser stage.
//  Branch/jump resolution redirects the PC and flushes the queue.
// PARAMETERS
//  DEPTH     4   FIFO entries; power of two, >= 2
//  RESET_PC  0   fetch PC loaded at reset (64-bit)
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  reset           in   1   asynchronous, active-low (0 = reset)
//  redirect_valid  in   1   branch/jump taken; load redirect_pc, flush queue
//  redirect_pc     in   64  new fetch address; bits [1:0] ignored and forced to 0
//  imem_req        out  1   memory request valid
//  imem_addr       out  64  request word address; stable while imem_req=1
//  imem_ack        in   1   request done this cycle; imem_rdata valid with it
//  imem_rdata      in   32  fetched instruction
//  out_valid       out  1   queue head valid (FIFO not empty)
//  out_instr       out  32  head instruction
//  out_pc          out  64  PC of head instruction
//  out_ready       in   1   consumer takes head when out_valid=1
// BEHAVIOUR
//  Reset (reset=0, async): fetch_pc=RESET_PC; FIFO empty; state=IDLE.
//   Outputs: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
//  FSM states:
//   IDLE:  imem_req=0. Go to REQ when count+1 <= DEPTH (credit free) and no redirect.
//   REQ:   imem_req=1, imem_addr=fetch_pc.
//          On ack: push {fetch_pc, imem_rdata}; fetch_pc += 4.
//          Stay in REQ if a credit remains after the push, else go to IDLE.
//   DRAIN: imem_req=1 with the stale address held. On ack: drop data, go to IDLE.
//  Single outstanding request. Credit test includes same-cycle pop, so push never
//   overflows.
//  Redirect (highest priority, same edge):
//   - fetch_pc <= {redirect_pc[63:2],2'b00}; FIFO cleared; any same-cycle pop ignored.
//   - From REQ without ack: go to DRAIN; imem_addr stays stale until ack.
//   - From REQ with ack, or from DRAIN with ack: data dropped; go to IDLE.
//   - From DRAIN without ack: stay in DRAIN; fetch_pc updated again.
//   - From IDLE: stay in IDLE.
//   - First request to the new PC issues the cycle after leaving IDLE.
//  Output is first-word-fall-through: out_valid = (count!=0). Pop on out_valid & out_ready.
//   Push and pop in the same cycle: count unchanged; head/tail pointers wrap mod DEPTH.
//  Latency: ack at edge N -> out_valid=1 after edge N (if FIFO was empty).
//   Back-to-back ack cycles give 1 instr/cycle.
//  PC arithmetic is modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
//  out_instr/out_pc hold the last head value when empty.
//  imem_ack while imem_req=0 is ignored.
//  Reset mid-request: abandon immediately; no drain; memory must tolerate a dropped req.
// TESTING
//  1 Reset release, ack every cycle, out_ready=1 -> out_pc 0,4,8,...
//    out_instr = mem[pc>>2]; out_valid from cycle 2.
//  2 out_ready=0, ack always -> exactly DEPTH=4 pushes (pc 0..C).
//    imem_req drops to 0; out_valid holds. Then out_ready=1 -> fetch resumes at 0x10.
//  3 Ack latency 3 cycles; redirect_valid with redirect_pc=0x103 mid-request
//    -> stale ack discarded. Next imem_addr=0x100; FIFO empty meanwhile.
//  4 Redirect in same cycle as ack and pop with FIFO holding 2
//    -> count=0, out_valid=0. Next out_pc equals redirect target.
//  5 RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> out_pc sequence ..FFF8, ..FFFC, 0x0.
//  6 Assert reset=0 while imem_req=1 and FIFO holds 3 -> immediately imem_req=0,
//    out_valid=0. After release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues one outstanding word request at a
// time to a variable-latency instruction memory, and queues {pc, instr}
// pairs in a small first-word-fall-through FIFO for the decode stage.
// A redirect reloads the PC, flushes the queue and abandons any in-flight
// request (its late ack is drained and discarded).
module fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Fetch control state
    state_e      state_q;
    logic        imem_req_q;
    logic [63:0] imem_addr_q;
    logic [63:0] fetch_pc_q;

    // Queue state
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_after_pop;
    entry_t           out_q;

    logic        push;
    logic        pop;
    logic        credit_free;
    logic [63:0] redirect_target;
    logic [63:0] pc_plus4;
    entry_t      push_entry;

    // Handshake decode, occupancy arithmetic and credit test for this edge.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        pop             = out_valid & out_ready & ~redirect_valid;
        push            = (state_q == REQ) & imem_ack & ~redirect_valid;
        count_after_pop = count_q - CNT_W'(pop);
        count_d         = count_after_pop + CNT_W'(push);
        head_d          = head_q + PTR_W'(pop);
        tail_d          = tail_q + PTR_W'(push);
        // Credit counts the same-cycle pop, so a request is only ever issued
        // when its data is guaranteed a free slot.
        credit_free     = (count_d < CNT_W'(DEPTH));
        redirect_target = redirect_pc & ~64'h3;
        pc_plus4        = fetch_pc_q + 64'd4;
        push_entry      = '{pc: fetch_pc_q, instr: imem_rdata};
    end

    // Request FSM: fetch PC, request valid and held request address.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_target;
            if ((state_q == REQ || state_q == DRAIN) && !imem_ack) begin
                // Request still in flight: keep it asserted with the stale
                // address until the memory acks, then throw the data away.
                state_q    <= DRAIN;
                imem_req_q <= 1'b1;
            end else begin
                state_q    <= IDLE;
                imem_req_q <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (credit_free) begin
                        state_q     <= REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        fetch_pc_q <= pc_plus4;
                        if (credit_free) begin
                            imem_addr_q <= pc_plus4;
                        end else begin
                            state_q    <= IDLE;
                            imem_req_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_q    <= IDLE;
                        imem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers, occupancy and the registered head presented downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            out_q   <= '0;
        end else if (redirect_valid) begin
            // Flush; the visible head keeps its last value while empty.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (count_d != '0) begin
                // If nothing older survives this edge, the new head is the
                // word being pushed right now rather than a stored entry.
                out_q <= (count_after_pop == '0) ? push_entry : mem_q[head_d];
            end
        end
    end

    // Queue storage write port.
    // NOTE: the storage array is not reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign out_valid = (count_q != '0);
    assign out_instr = out_q.instr;
    assign out_pc    = out_q.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: a randomized memory responder and
// consumer, a transaction-level reference model (expected queue of
// {pc, instr} plus the fetch PC and a "stale request outstanding" flag),
// and a separate monitor that pops and compares whenever the DUT shows a head.
module tb_fetch_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [63:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFF8;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready = 1'b0;

    // Second instance exercising the PC wrap from a reset PC near the top.
    logic        w_req;
    logic [63:0] w_addr;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [63:0] w_pc;
    logic [31:0] w_rdata;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        exp_q[$];
    logic [63:0] model_pc = RESET_PC;
    bit          drain = 1'b0;

    int  lat_lo = 0, lat_hi = 0, cur_lat = 0, wait_cnt = 0;
    bit  idle_noise = 1'b0;

    always #5 clk = ~clk;

    // Memory image: instruction word as a scrambled function of its address.
    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return (pc[31:0] * 32'h9E37_79B1) ^ pc[63:32] ^ 32'h1357_9BDF;
    endfunction

    assign w_rdata = instr_of(w_addr);

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (1'b0),
        .redirect_pc    (64'h0),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ack       (1'b1),
        .imem_rdata     (w_rdata),
        .out_valid      (w_valid),
        .out_instr      (w_instr),
        .out_pc         (w_pc),
        .out_ready      (1'b1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ack after a random number of wait cycles per request.
    task automatic respond();
        if (imem_req) begin
            if (wait_cnt >= cur_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = instr_of(imem_addr);
                wait_cnt   = 0;
                cur_lat    = int'($urandom_range(lat_hi, lat_lo));
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            wait_cnt   = 0;
            imem_ack   = idle_noise && ($urandom_range(3, 0) == 0);
            imem_rdata = $urandom;
        end
    endtask

    // One clock: inputs change just after the rising edge.
    task automatic cycle(input logic rdy, input logic redir, input logic [63:0] rpc);
        @(posedge clk);
        #1;
        respond();
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic set_lat(input int lo, input int hi);
        lat_lo  = lo;
        lat_hi  = hi;
        cur_lat = lo;
    endtask

    task automatic wait_req(input logic level, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req == level) begin
                seen = 1'b1;
                break;
            end
            cycle(1'b1, 1'b0, 64'h0);
        end
        if (!seen) check(name, 64'(imem_req), 64'(level));
    endtask

    // Monitor: compare the presented head, pop when the consumer takes it.
    always @(negedge clk) begin
        if (reset) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                check("out_pc", out_pc, exp_q[0].pc);
                check("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                if (out_ready && !redirect_valid) void'(exp_q.pop_front());
            end
        end
    end

    // Reference model: predicts the effect of the coming edge on the queue.
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            exp_q.delete();
            model_pc = RESET_PC;
            drain    = 1'b0;
        end else begin
            if (imem_req && !drain) check("imem_addr", imem_addr, model_pc);
            if (redirect_valid) begin
                exp_q.delete();
                if (imem_req) drain = !imem_ack;
                model_pc = redirect_pc & ~64'h3;
            end else if (imem_req && imem_ack) begin
                if (drain) begin
                    drain = 1'b0;
                end else begin
                    exp_q.push_back('{pc: model_pc, instr: instr_of(model_pc)});
                    model_pc = model_pc + 64'd4;
                    check("fifo_bound", 64'(exp_q.size() <= DEPTH), 64'd1);
                end
            end
        end
    end

    // Wrap instance: ack and ready always high, so the PCs stream in order.
    logic [63:0] wexp = WRAP_PC;
    int          w_seen = 0;
    always @(negedge clk) begin
        if (!reset) begin
            wexp   = WRAP_PC;
            w_seen = 0;
        end else if (w_valid && w_seen < 6) begin
            check("wrap_pc", w_pc, wexp);
            check("wrap_instr", 64'(w_instr), 64'(instr_of(wexp)));
            wexp = wexp + 64'd4;
            w_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rpc;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        reset = 1'b1;

        // Ack every cycle, consumer always ready.
        set_lat(0, 0);
        cycle(1'b1, 1'b0, 64'h0);
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", imem_addr, RESET_PC);
        cycle(1'b1, 1'b0, 64'h0);
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_pc", out_pc, RESET_PC);
        repeat (10) cycle(1'b1, 1'b0, 64'h0);

        // Consumer stalls: exactly DEPTH pushes, then requests stop.
        repeat (10) cycle(1'b0, 1'b0, 64'h0);
        check("stall_req", 64'(imem_req), 64'd0);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_fill", 64'(exp_q.size()), 64'(DEPTH));
        cycle(1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 64'h0);
        check("resume_req", 64'(imem_req), 64'd1);
        repeat (6) cycle(1'b1, 1'b0, 64'h0);

        // Redirect while a slow request is in flight: stale ack is dropped.
        set_lat(3, 3);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 64'h0);
            if (imem_req && !imem_ack) break;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        cycle(1'b1, 1'b0, 64'h0);
        check("drain_req", 64'(imem_req), 64'd1);
        check("drain_empty", 64'(out_valid), 64'd0);
        wait_req(1'b0, "drain_done");
        wait_req(1'b1, "redirect_req");
        check("redirect_addr", imem_addr, 64'h100);
        check("redirect_empty", 64'(out_valid), 64'd0);

        // Redirect on the same edge as an ack and a pop, with two queued.
        set_lat(0, 0);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 2 && imem_req) break;
            cycle(1'b0, 1'b0, 64'h0);
        end
        check("pre_flush_cnt", 64'(exp_q.size()), 64'd2);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        cycle(1'b1, 1'b0, 64'h0);
        check("flush_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            cycle(1'b1, 1'b0, 64'h0);
        end
        check("flush_next_pc", out_pc, 64'h200);

        // Randomized traffic: variable latency, stalls, redirects, idle acks.
        set_lat(0, 3);
        idle_noise = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rpc = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) rpc[63:8] = '1;
            cycle($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0, rpc);
        end

        // Reset in the middle of a request with three entries queued.
        set_lat(0, 1);
        idle_noise = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 3 && imem_req) break;
            cycle(1'b0, 1'b0, 64'h0);
        end
        check("pre_reset_cnt", 64'(exp_q.size()), 64'd3);
        reset = 1'b0;
        #1;
        check("mid_rst_req", 64'(imem_req), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        cycle(1'b1, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 64'h0);
        reset = 1'b1;
        wait_req(1'b1, "post_rst_req");
        check("post_rst_addr", imem_addr, RESET_PC);
        repeat (20) cycle(1'b1, 1'b0, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
